mips_if_stage: RTL

- Instruction-fetch stage of the 5-stage MIPS pipeline, instantiated inside MIPS_PIPELINE_TOP. It feeds the decode stage through the IF/ID pipeline register.
- Owns the PC and drives a synchronous-read instruction memory, which returns data one cycle after the address.
- Handles hazard-unit stalls with a skid register. Handles taken-branch/jump redirects by squashing the in-flight fetch and the IF/ID contents.

---
 rtl/mips_pipe_pkg.sv | 30 +++
 rtl/mips_if_skid.sv | 38 +++
 rtl/mips_if_stage.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mips_pipe_pkg.sv
// +--------------------------------------------------------------------------+
// | mips_pipe_pkg : shared pipeline types and constants for the MIPS core    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package mips_pipe_pkg;

  localparam logic [31:0] c_nop_instr = 32'h0000_0000;  // sll $0,$0,0
  localparam logic [31:0] c_reset_pc  = 32'h0000_0000;
  localparam logic [31:0] c_pc_step   = 32'd4;

  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } if_state_t;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mips_if_skid.sv
// +--------------------------------------------------------------------------+
// | mips_if_skid : one-entry 32-bit skid register for the fetch stage        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module mips_if_skid (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_capture,
  input  logic        i_clear,
  input  logic [31:0] i_data,
  output logic [31:0] o_data,
  output logic        o_valid
);

  logic [31:0] r_data;
  logic        r_valid;

  // Only the first capture after a clear is kept; later ones would be stale.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data  <= 32'h0;
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_capture && !r_valid) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

`default_nettype wire

// File: rtl/mips_if_stage.sv
// +--------------------------------------------------------------------------+
// | mips_if_stage : MIPS instruction fetch stage (PC, imem issue, IF/ID reg) |
// | Optional perf counters enabled by macro MIPS_IF_PERF_CNT_EN              |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module mips_if_stage
  import mips_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = c_reset_pc,
  parameter logic [31:0] NOP_INSTR = c_nop_instr
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  output logic        imem_rd_o,
  input  logic [31:0] imem_data_i,
  output logic [31:0] ifid_pc4_o,
  output logic [31:0] ifid_instr_o,
  output logic        ifid_valid_o
`ifdef MIPS_IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_o,
  output logic [31:0] perf_stall_o,
  output logic [31:0] perf_squash_o
`endif
);

  if_state_t   r_state;
  logic [31:0] r_pc;
  logic [31:0] r_inflight_pc;
  logic        r_inflight_valid;
  ifid_t       r_ifid;

  logic        w_boot;
  logic        w_issue;
  logic        w_advance;
  logic        w_stall;
  logic        w_skid_valid;
  logic [31:0] w_skid_data;
  logic [31:0] w_fetch_data;

  assign w_boot    = (r_state == BOOT);
  assign w_issue   = reset & (w_boot | ~stall_i | redirect_i);
  assign w_advance = ~w_boot & ~stall_i & ~redirect_i;
  assign w_stall   = stall_i & ~redirect_i;

  // Redirect target goes straight to memory so only one slot is squashed.
  assign imem_addr_o = redirect_i ? redirect_pc_i : r_pc;
  assign imem_rd_o   = w_issue;

  mips_if_skid u_skid (
    .clk       (clk),
    .reset     (reset),
    .i_capture (w_stall & ~w_boot & r_inflight_valid),
    .i_clear   (w_advance | redirect_i),
    .i_data    (imem_data_i),
    .o_data    (w_skid_data),
    .o_valid   (w_skid_valid)
  );

  assign w_fetch_data = w_skid_valid ? w_skid_data : imem_data_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state          <= BOOT;
      r_pc             <= RESET_PC;
      r_inflight_pc    <= RESET_PC;
      r_inflight_valid <= 1'b0;
      r_ifid           <= '{pc4: 32'h0, instr: NOP_INSTR, valid: 1'b0};
    end else begin
      r_state <= RUN;

      if (redirect_i)
        r_pc <= redirect_pc_i + c_pc_step;
      else if (w_issue)
        r_pc <= r_pc + c_pc_step;

      if (w_issue) begin
        r_inflight_pc    <= imem_addr_o;
        r_inflight_valid <= 1'b1;
      end

      if (redirect_i) begin
        r_ifid.valid <= 1'b0;
        r_ifid.instr <= NOP_INSTR;
      end else if (w_advance) begin
        r_ifid.pc4   <= r_inflight_pc + c_pc_step;
        r_ifid.instr <= r_inflight_valid ? w_fetch_data : NOP_INSTR;
        r_ifid.valid <= r_inflight_valid;
      end
    end
  end

  assign ifid_pc4_o   = r_ifid.pc4;
  assign ifid_instr_o = r_ifid.instr;
  assign ifid_valid_o = r_ifid.valid;

`ifdef MIPS_IF_PERF_CNT_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_squash;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_fetch  <= 32'h0;
      r_perf_stall  <= 32'h0;
      r_perf_squash <= 32'h0;
    end else begin
      if (w_advance && r_inflight_valid) r_perf_fetch  <= sat_inc(r_perf_fetch);
      if (w_stall)                       r_perf_stall  <= sat_inc(r_perf_stall);
      if (redirect_i)                    r_perf_squash <= sat_inc(r_perf_squash);
    end
  end

  assign perf_fetch_o  = r_perf_fetch;
  assign perf_stall_o  = r_perf_stall;
  assign perf_squash_o = r_perf_squash;
`endif

endmodule

`default_nettype wire
